roi_addr_gen: RTL and testbench

ROI_ADDR_GEN -- requirements
Module: roi_addr_gen

---
 rtl/roi_addr_gen_pkg.sv | 19 +
 rtl/roi_addr_gen_addr_pipe.sv | 97 +++++++++
 rtl/roi_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_roi_addr_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/roi_addr_gen_pkg.sv
// Shared save-path parameters: frame-size defaults, FSM encodings and a
// helper for sizing the bank index.
package roi_addr_gen_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A bank index needs at least one bit even for a single-bank buffer.
  function automatic int bank_width(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/roi_addr_gen_addr_pipe.sv
// Two-stage coordinate-to-address pipeline. S1 clamps the coordinate and
// captures the bank; S2 forms bank*frame + y*width + x. Each stage loads
// whenever it is empty or the stage after it is draining.
module addr_pipe
  import roi_addr_gen_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int COORD_W = 13,
  parameter int ADDR_W  = 20,
  parameter int BANK_W  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coord_valid,
  output logic               coord_ready,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [BANK_W-1:0]  bank,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic               oor,
  output logic               busy
);

  localparam int FRAME = H_RES * V_RES;

  logic               s1_valid;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;
  logic [BANK_W-1:0]  s1_bank;
  logic               s1_oor;

  logic               s2_ready;
  logic               s1_ready;
  logic               x_over;
  logic               y_over;
  logic [COORD_W-1:0] x_clamp;
  logic [COORD_W-1:0] y_clamp;
  logic [ADDR_W-1:0]  addr_calc;

  assign s2_ready    = !addr_valid || addr_ready;
  assign s1_ready    = !s1_valid || s2_ready;
  assign coord_ready = s1_ready;
  assign busy        = s1_valid || addr_valid;

  // Clamp to the last pixel and form the address at full ADDR_W width.
  always_comb begin
    // NOTE: every output of this block is given a value up front so no
    // path through it can leave a signal unassigned and infer a latch.
    x_over  = (x >= COORD_W'(H_RES));
    y_over  = (y >= COORD_W'(V_RES));
    x_clamp = x_over ? COORD_W'(H_RES - 1) : x;
    y_clamp = y_over ? COORD_W'(V_RES - 1) : y;
    addr_calc = ADDR_W'(s1_bank) * ADDR_W'(FRAME)
              + ADDR_W'(s1_y) * ADDR_W'(H_RES)
              + ADDR_W'(s1_x);
  end

  // S1: clamped coordinate, sampled bank and out-of-range flag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_bank  <= '0;
      s1_oor   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= coord_valid;
      if (coord_valid) begin
        s1_x    <= x_clamp;
        s1_y    <= y_clamp;
        s1_bank <= bank;
        s1_oor  <= x_over || y_over;
      end
    end
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_valid <= 1'b0;
      addr       <= '0;
      oor        <= 1'b0;
    end else if (s2_ready) begin
      addr_valid <= s1_valid;
      if (s1_valid) begin
        addr <= addr_calc;
        oor  <= s1_oor;
      end
    end
  end

endmodule

// File: rtl/roi_addr_gen.sv
// Frame-buffer address generator: converts single coordinates or raster-
// scans a rectangular ROI, with a deferred bank-advance request.
module roi_addr_gen
  import roi_addr_gen_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int COORD_W = 13,
  parameter int ADDR_W  = 20,
  parameter int NBANK   = 2,
  localparam int BANK_W = bank_width(NBANK)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iMODE,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  input  logic               iVALID,
  output logic               oREADY,
  input  logic               iSTART,
  input  logic [COORD_W-1:0] iX0,
  input  logic [COORD_W-1:0] iY0,
  input  logic [COORD_W-1:0] iX1,
  input  logic [COORD_W-1:0] iY1,
  input  logic               iBANK_SWAP,
  output logic [ADDR_W-1:0]  oADDR,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oOOR,
  output logic [BANK_W-1:0]  oBANK,
  output logic               oDONE,
  output logic               oERR
);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] cur_x_q, cur_y_q;
  logic [COORD_W-1:0] x0_q, x1_q, y1_q;
  logic [BANK_W-1:0]  bank_q;
  logic               pending_q;
  logic               done_q, err_q;

  logic               pipe_valid;
  logic               pipe_ready;
  logic               pipe_busy;
  logic [COORD_W-1:0] pipe_x, pipe_y;
  logic               roi_ok;
  logic               start_req;
  logic               scan_step;
  logic               scan_last;
  logic               drain_exit;
  logic               bank_apply;

  assign roi_ok = (iX0 <= iX1) && (iY0 <= iY1) &&
                  (iX1 < COORD_W'(H_RES)) && (iY1 < COORD_W'(V_RES));
  assign start_req  = (state_q == ST_IDLE) && iSTART && iMODE;
  assign scan_step  = (state_q == ST_SCAN) && pipe_ready;
  assign scan_last  = (cur_x_q == x1_q) && (cur_y_q == y1_q);
  assign drain_exit = (state_q == ST_DRAIN) && !pipe_busy;
  assign bank_apply = pending_q && ((state_q == ST_IDLE) || drain_exit);

  assign oREADY = (state_q == ST_IDLE) && !iMODE && pipe_ready && !iRST;
  assign oBANK  = bank_q;
  assign oDONE  = done_q;
  assign oERR   = err_q;

  // Next-state logic and pipeline-input selection.
  always_comb begin
    state_d    = state_q;
    pipe_valid = 1'b0;
    pipe_x     = iX;
    pipe_y     = iY;
    unique case (state_q)
      ST_IDLE: begin
        pipe_valid = iVALID && !iMODE;
        if (start_req && roi_ok) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        pipe_valid = 1'b1;
        pipe_x     = cur_x_q;
        pipe_y     = cur_y_q;
        if (scan_step && scan_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus the one-cycle done/error pulses.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_exit;
      err_q   <= start_req && !roi_ok;
    end
  end

  // ROI latch on start and raster cursor advance while scanning.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else if (start_req && roi_ok) begin
      cur_x_q <= iX0;
      cur_y_q <= iY0;
      x0_q    <= iX0;
      x1_q    <= iX1;
      y1_q    <= iY1;
    end else if (scan_step && !scan_last) begin
      if (cur_x_q == x1_q) begin
        cur_x_q <= x0_q;
        cur_y_q <= cur_y_q + COORD_W'(1);
      end else begin
        cur_x_q <= cur_x_q + COORD_W'(1);
      end
    end
  end

  // Bank advance: a request is remembered and applied when the FSM is idle
  // or finishing a scan; a pulse that lands on the apply edge is absorbed.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bank_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (bank_apply) begin
        bank_q    <= (bank_q == BANK_W'(NBANK - 1)) ? '0 : bank_q + BANK_W'(1);
        pending_q <= 1'b0;
      end else if (iBANK_SWAP) begin
        pending_q <= 1'b1;
      end
    end
  end

  addr_pipe #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .BANK_W  (BANK_W)
  ) u_pipe (
    .clk         (iCLK),
    .rst         (iRST),
    .coord_valid (pipe_valid),
    .coord_ready (pipe_ready),
    .x           (pipe_x),
    .y           (pipe_y),
    .bank        (bank_q),
    .addr_valid  (oVALID),
    .addr_ready  (iREADY),
    .addr        (oADDR),
    .oor         (oOOR),
    .busy        (pipe_busy)
  );

endmodule

// File: tb/tb_roi_addr_gen.sv
// Directed bench for roi_addr_gen: convert mode, bank swaps, clamping,
// ROI scans with and without back-pressure, rejected ROI and mid-scan reset.
module tb_roi_addr_gen;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iMODE;
  logic [12:0] iX, iY;
  logic        iVALID;
  logic        oREADY;
  logic        iSTART;
  logic [12:0] iX0, iY0, iX1, iY1;
  logic        iBANK_SWAP;
  logic [19:0] oADDR;
  logic        oVALID;
  logic        iREADY;
  logic        oOOR;
  logic [0:0]  oBANK;
  logic        oDONE;
  logic        oERR;

  int errors = 0;
  int checks = 0;

  always #5 iCLK = ~iCLK;

  roi_addr_gen dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iMODE      (iMODE),
    .iX         (iX),
    .iY         (iY),
    .iVALID     (iVALID),
    .oREADY     (oREADY),
    .iSTART     (iSTART),
    .iX0        (iX0),
    .iY0        (iY0),
    .iX1        (iX1),
    .iY1        (iY1),
    .iBANK_SWAP (iBANK_SWAP),
    .oADDR      (oADDR),
    .oVALID     (oVALID),
    .iREADY     (iREADY),
    .oOOR       (oOOR),
    .oBANK      (oBANK),
    .oDONE      (oDONE),
    .oERR       (oERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One convert-mode transfer issued at a falling edge; the result must
  // appear after the second rising edge and be consumed on the third.
  task automatic convert(input int x, input int y, input int exp_addr,
                         input bit exp_oor, input string tag);
    iMODE  = 1'b0;
    iX     = 13'(x);
    iY     = 13'(y);
    iVALID = 1'b1;
    #1 check({tag, "_ready"}, 32'(oREADY), 32'd1);
    @(negedge iCLK);
    iVALID = 1'b0;
    check({tag, "_early"}, 32'(oVALID), 32'd0);
    @(negedge iCLK);
    check({tag, "_valid"}, 32'(oVALID), 32'd1);
    check({tag, "_addr"}, 32'(oADDR), 32'(exp_addr));
    check({tag, "_oor"}, 32'(oOOR), 32'(exp_oor));
    @(negedge iCLK);
    check({tag, "_empty"}, 32'(oVALID), 32'd0);
  endtask

  // Start a scan at the current falling edge and collect every consumed
  // address until oDONE, optionally stalling the consumer for 3 cycles.
  task automatic run_scan(input int x0, input int y0, input int x1, input int y1,
                          input int base, input bit stall, input string tag);
    int exp_q[$];
    int got;
    int dones;
    int stall_cnt;
    bit stalled;
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        exp_q.push_back(base + yy * 320 + xx);
    iMODE  = 1'b1;
    iX0    = 13'(x0);
    iY0    = 13'(y0);
    iX1    = 13'(x1);
    iY1    = 13'(y1);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    check({tag, "_busy_ready"}, 32'(oREADY), 32'd0);
    got       = 0;
    dones     = 0;
    stall_cnt = 0;
    stalled   = 1'b0;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      if (stall && !stalled && got == 2) begin
        stalled   = 1'b1;
        stall_cnt = 3;
      end
      if (stall_cnt > 0) begin
        iREADY = 1'b0;
        check({tag, "_stall_valid"}, 32'(oVALID), 32'd1);
        check({tag, "_stall_hold"}, 32'(oADDR), 32'(exp_q[2]));
        stall_cnt--;
      end else begin
        iREADY = 1'b1;
      end
      if (iREADY && oVALID) begin
        if (got < exp_q.size())
          check($sformatf("%s_addr%0d", tag, got), 32'(oADDR), 32'(exp_q[got]));
        got++;
      end
      if (oDONE) dones++;
      @(negedge iCLK);
    end
    iREADY = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
    check({tag, "_done"}, 32'(dones), 32'd1);
    check({tag, "_done_single"}, 32'(oDONE), 32'd0);
    check({tag, "_idle_valid"}, 32'(oVALID), 32'd0);
  endtask

  initial begin
    iRST       = 1'b1;
    iMODE      = 1'b0;
    iX         = '0;
    iY         = '0;
    iVALID     = 1'b0;
    iSTART     = 1'b0;
    iX0        = '0;
    iY0        = '0;
    iX1        = '0;
    iY1        = '0;
    iBANK_SWAP = 1'b0;
    iREADY     = 1'b1;

    // Reset state, including oREADY held low while reset is asserted.
    #1;
    check("rst_addr", 32'(oADDR), 32'd0);
    check("rst_valid", 32'(oVALID), 32'd0);
    check("rst_ready", 32'(oREADY), 32'd0);
    check("rst_bank", 32'(oBANK), 32'd0);
    check("rst_done_err", 32'({oDONE, oERR, oOOR}), 32'd0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;

    // Plain conversion: 2*320 + 5.
    convert(5, 2, 645, 1'b0, "conv_5_2");

    // Bank swap in IDLE: pending after one edge, applied on the next.
    iBANK_SWAP = 1'b1;
    @(negedge iCLK);
    iBANK_SWAP = 1'b0;
    check("swap_pending", 32'(oBANK), 32'd0);
    @(negedge iCLK);
    check("swap_applied", 32'(oBANK), 32'd1);
    convert(0, 0, 76800, 1'b0, "conv_bank1");

    // A two-cycle request counts as a single swap: 1 -> 0 and stays there.
    iBANK_SWAP = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    iBANK_SWAP = 1'b0;
    check("swap_back", 32'(oBANK), 32'd0);
    @(negedge iCLK);
    check("swap_once", 32'(oBANK), 32'd0);

    // x clamped to 319: 10*320 + 319.
    convert(400, 10, 3519, 1'b1, "conv_clamp_x");
    // y clamped to 239: 239*320 + 7.
    convert(7, 500, 76487, 1'b1, "conv_clamp_y");

    // Scan across the right edge, free-flowing then with back-pressure.
    run_scan(318, 0, 319, 1, 0, 1'b0, "scan");
    run_scan(318, 0, 319, 1, 0, 1'b1, "scan_stall");

    // Rejected ROI: X0 > X1.
    iMODE  = 1'b1;
    iX0    = 13'd10;
    iY0    = 13'd0;
    iX1    = 13'd5;
    iY1    = 13'd0;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    check("err_pulse", 32'(oERR), 32'd1);
    check("err_no_valid", 32'(oVALID), 32'd0);
    @(negedge iCLK);
    check("err_single", 32'(oERR), 32'd0);
    check("err_no_valid2", 32'(oVALID), 32'd0);
    iMODE = 1'b0;
    #1 check("err_idle_ready", 32'(oREADY), 32'd1);
    @(negedge iCLK);

    // Swap request lands on the same edge as the start: scan uses bank 1.
    iBANK_SWAP = 1'b1;
    @(negedge iCLK);
    iBANK_SWAP = 1'b0;
    run_scan(318, 0, 319, 0, 76800, 1'b0, "scan_swap");
    check("scan_swap_bank", 32'(oBANK), 32'd1);

    // Reset in the middle of a large scan, then a clean scan afterwards.
    iMODE  = 1'b1;
    iX0    = 13'd0;
    iY0    = 13'd0;
    iX1    = 13'd9;
    iY1    = 13'd9;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (4) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    check("midrst_addr", 32'(oADDR), 32'd0);
    check("midrst_valid", 32'(oVALID), 32'd0);
    check("midrst_flags", 32'({oDONE, oERR, oOOR, oREADY}), 32'd0);
    check("midrst_bank", 32'(oBANK), 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge iCLK);
      check($sformatf("postrst_quiet%0d", c), 32'({oVALID, oDONE}), 32'd0);
    end
    run_scan(318, 0, 319, 1, 0, 1'b0, "postrst_scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
